decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction decode stage for the Aurora CPU. It accepts a 32-bit RV32I instruction word and PC from fetch over a valid/ready handshake. It produces the control bundle the ALU and the rest of execute consume: `inst_type`, `alu_op_type`, the sign-extended immediate (`sext_out`), register indices and memory/branch flags. It sits between the fetch buffer and the register-file read/execute stage, and supplies the producer side of the ALU operand/opcode interface.

## Interface
Parameters:
- `ILL_CNT_W`, 16, width of the saturating illegal-instruction counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage can accept.
- `in_inst` in 32: instruction word.
- `in_pc` in 32: its PC.
- `flush` in 1: discard all held/in-flight instructions.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_pc` out 32: PC of the decoded instruction.
- `inst_type` out 5: `INST_*` class from cpu.vh.
- `alu_op_type` out 4: `ALU_*` opcode from cpu.vh.
- `sext_out` out 32: immediate.
- `rs1`, `rs2`, `rd` out 5 each: register indices.
- `rd_we` out 1: writes `rd`.
- `mem_rd`, `mem_wr`, `branch`, `jump` out 1 each: class flags.
- `illegal` out 1: unsupported encoding.
- `ill_cnt` out `ILL_CNT_W`: count of illegal instructions delivered.

## Operation
Decode of supported encodings:
- R-type (0110011): `INST_R`.
  - ADD/SUB use funct7 bit 30 to select `ALU_ADD`/`ALU_SUB`.
  - AND, OR, XOR, SLL, SRL map to the matching op; SRA (funct7=0x20) maps to `ALU_SRA`.
  - SLT maps to `ALU_LT`.
  - `rd_we=1`.
- OP-IMM (0010011): `INST_I`, same mapping as R-type with no SUB.
  - `sext_out` = sign-extended inst[31:20].
  - For SLLI/SRLI/SRAI, `sext_out` = zero-extended inst[24:20] (shamt only), so the ALU shifts by the shamt alone.
- LOAD LW (0000011): `INST_I`, `ALU_ADD`, `mem_rd=1`, `rd_we=1`.
- STORE SW (0100011): `INST_S`, `ALU_ADD`, `mem_wr=1`, `rd_we=0`, S-immediate.
- BRANCH (1100011): `INST_B`, `branch=1`, `rd_we=0`, B-immediate with bit0=0.
  - BEQ, BNE, BLT, BGE map to `ALU_EQ`, `ALU_NE`, `ALU_LT`, `ALU_GE`.
- LUI (0110111): `INST_U`, `ALU_SLL`, `sext_out` = {{12{inst[31]}}, inst[31:12]}, `rd_we=1`. The ALU supplies the shift of 12.
- JAL (1101111): `INST_J`, `ALU_ADD`, `jump=1`, `rd_we=1`, J-immediate.
- JALR (1100111): `INST_I`, `ALU_ADD`, `jump=1`, `rd_we=1`.

Illegal encodings:
- Covers any other opcode/funct3/funct7, including SLTU, BLTU, BGEU, AUIPC, byte/half loads and stores, and SYSTEM.
- Output: `illegal=1`, `rd_we=mem_rd=mem_wr=branch=jump=0`, `alu_op_type=ALU_ADD`; other fields are decoded raw.
- `ill_cnt` increments by 1 on each out handshake with `illegal=1` and saturates at all-ones.

Field rules:
- `rs1`=inst[19:15], `rs2`=inst[24:20], `rd`=inst[11:7], always extracted.
- `rd_we` is forced to 0 when `rd`=0.

## Timing
- Reset: `out_valid=0`, all bundle outputs 0, `ill_cnt=0`, skid entry empty.
- Latency: an instruction accepted (`in_valid && in_ready`) at edge N is presented with `out_valid=1` after edge N.
- Output bundle is fully registered and stable while `out_valid && !out_ready`.
- `in_ready` is 0 while `flush=1`.
- `flush` at edge N: `out_valid=0` and skid emptied after N; any concurrent input is dropped; `ill_cnt` is unchanged.
- Reset mid-operation drops all held instructions immediately.
- Simultaneous out handshake and input acceptance: the new bundle replaces the old one with no bubble.

## Configuration
- `DECODE_SKID_EN` defined:
  - Adds a one-entry skid buffer; `in_ready` is a pure register output (`in_ready` = skid empty).
  - When output is stalled, one further instruction is absorbed into the skid.
  - After the stall releases, the skid entry is presented on the following edge.
- Undefined:
  - Single output register; `in_ready = !out_valid || out_ready` (combinational).
  - No instruction is absorbed during a stall.

## Test plan
- ADDI x1,x0,5 (0x00500093) -> next cycle `out_valid=1`, `INST_I`, `ALU_ADD`, `rd=1`, `rs1=0`, `sext_out=0x00000005`, `rd_we=1`.
- SUB x3,x1,x2 (0x402081B3), then SRAI x4,x1,3 (0x4030D213) -> bundle 1: `INST_R`, `ALU_SUB`, `rd=3`, `rs1=1`, `rs2=2`; bundle 2: `ALU_SRA`, `sext_out=0x00000003`.
- LUI x5,0x12345 (0x123452B7) -> `INST_U`, `ALU_SLL`, `sext_out=0x00012345`. BEQ x1,x2,-4 (0xFE208EE3) -> `INST_B`, `ALU_EQ`, `sext_out=0xFFFFFFFC`, `branch=1`, `rd_we=0`.
- BLTU x1,x2,0 (0x0020E063) delivered twice -> `illegal=1`, `rd_we=0`, `ill_cnt` 0->1->2. Pre-set counter near max -> holds at all-ones.
- `out_ready=0` for 3 cycles with `in_valid=1` -> bundle stable. With `DECODE_SKID_EN`, exactly one extra instruction is accepted, then `in_ready=0`, and both drain in order. Without it, `in_ready=0` throughout.
- `flush=1` with bundle (and skid) full and `in_valid=1` -> next cycle `out_valid=0`, the offered instruction is not accepted, and the next accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a valid/ready handshake on both sides.
// Optional one-entry skid buffer enabled by defining DECODE_SKID_EN.
module decode_stage #(
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [4:0]           inst_type,
    output logic [3:0]           alu_op_type,
    output logic [31:0]          sext_out,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic                 rd_we,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 branch,
    output logic                 jump,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [4:0] INST_NONE = 5'd0;
    localparam logic [4:0] INST_R    = 5'd1;
    localparam logic [4:0] INST_I    = 5'd2;
    localparam logic [4:0] INST_S    = 5'd3;
    localparam logic [4:0] INST_B    = 5'd4;
    localparam logic [4:0] INST_U    = 5'd5;
    localparam logic [4:0] INST_J    = 5'd6;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LT  = 4'd8;
    localparam logic [3:0] ALU_EQ  = 4'd9;
    localparam logic [3:0] ALU_NE  = 4'd10;
    localparam logic [3:0] ALU_GE  = 4'd11;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  itype;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_f7z;
    logic        w_f7a;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_shamt;

    assign w_opc   = in_inst[6:0];
    assign w_f3    = in_inst[14:12];
    assign w_f7z   = (in_inst[31:25] == 7'h00);
    assign w_f7a   = (in_inst[31:25] == 7'h20);
    assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u = {{12{in_inst[31]}}, in_inst[31:12]};
    assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
    assign w_shamt = {27'd0, in_inst[24:20]};

    logic        w_ok;
    logic        w_we;
    logic        w_mrd;
    logic        w_mwr;
    logic        w_br;
    logic        w_jmp;
    logic [3:0]  w_alu;
    logic [4:0]  w_type;
    logic [31:0] w_imm;
    bundle_t     w_dec;

    always_comb begin
        w_ok   = 1'b0;
        w_we   = 1'b0;
        w_mrd  = 1'b0;
        w_mwr  = 1'b0;
        w_br   = 1'b0;
        w_jmp  = 1'b0;
        w_alu  = ALU_ADD;
        w_type = INST_NONE;
        w_imm  = '0;
        case (w_opc)
            OPC_OP: begin
                w_type = INST_R;
                w_we   = 1'b1;
                case (w_f3)
                    3'b000: begin w_ok = w_f7z | w_f7a; w_alu = w_f7a ? ALU_SUB : ALU_ADD; end
                    3'b001: begin w_ok = w_f7z; w_alu = ALU_SLL; end
                    3'b010: begin w_ok = w_f7z; w_alu = ALU_LT;  end
                    3'b100: begin w_ok = w_f7z; w_alu = ALU_XOR; end
                    3'b101: begin w_ok = w_f7z | w_f7a; w_alu = w_f7a ? ALU_SRA : ALU_SRL; end
                    3'b110: begin w_ok = w_f7z; w_alu = ALU_OR;  end
                    3'b111: begin w_ok = w_f7z; w_alu = ALU_AND; end
                    default: ;
                endcase
            end
            OPC_IMM: begin
                w_type = INST_I;
                w_we   = 1'b1;
                w_imm  = w_imm_i;
                case (w_f3)
                    3'b000: begin w_ok = 1'b1; w_alu = ALU_ADD; end
                    3'b010: begin w_ok = 1'b1; w_alu = ALU_LT;  end
                    3'b100: begin w_ok = 1'b1; w_alu = ALU_XOR; end
                    3'b110: begin w_ok = 1'b1; w_alu = ALU_OR;  end
                    3'b111: begin w_ok = 1'b1; w_alu = ALU_AND; end
                    // shifts carry only the shamt so the ALU ignores funct7
                    3'b001: begin w_ok = w_f7z; w_alu = ALU_SLL; w_imm = w_shamt; end
                    3'b101: begin
                        w_ok  = w_f7z | w_f7a;
                        w_alu = w_f7a ? ALU_SRA : ALU_SRL;
                        w_imm = w_shamt;
                    end
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                w_type = INST_I;
                w_imm  = w_imm_i;
                w_ok   = (w_f3 == 3'b010);
                w_mrd  = 1'b1;
                w_we   = 1'b1;
            end
            OPC_STORE: begin
                w_type = INST_S;
                w_imm  = w_imm_s;
                w_ok   = (w_f3 == 3'b010);
                w_mwr  = 1'b1;
            end
            OPC_BR: begin
                w_type = INST_B;
                w_imm  = w_imm_b;
                w_br   = 1'b1;
                case (w_f3)
                    3'b000: begin w_ok = 1'b1; w_alu = ALU_EQ; end
                    3'b001: begin w_ok = 1'b1; w_alu = ALU_NE; end
                    3'b100: begin w_ok = 1'b1; w_alu = ALU_LT; end
                    3'b101: begin w_ok = 1'b1; w_alu = ALU_GE; end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                w_type = INST_U;
                w_imm  = w_imm_u;
                w_alu  = ALU_SLL;
                w_ok   = 1'b1;
                w_we   = 1'b1;
            end
            OPC_JAL: begin
                w_type = INST_J;
                w_imm  = w_imm_j;
                w_ok   = 1'b1;
                w_jmp  = 1'b1;
                w_we   = 1'b1;
            end
            OPC_JALR: begin
                w_type = INST_I;
                w_imm  = w_imm_i;
                w_ok   = (w_f3 == 3'b000);
                w_jmp  = 1'b1;
                w_we   = 1'b1;
            end
            default: ;
        endcase

        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.itype   = w_type;
        w_dec.imm     = w_imm;
        w_dec.rs1     = in_inst[19:15];
        w_dec.rs2     = in_inst[24:20];
        w_dec.rd      = in_inst[11:7];
        w_dec.illegal = ~w_ok;
        w_dec.alu     = w_ok ? w_alu : ALU_ADD;
        w_dec.rd_we   = w_ok & w_we & (in_inst[11:7] != 5'd0);
        w_dec.mem_rd  = w_ok & w_mrd;
        w_dec.mem_wr  = w_ok & w_mwr;
        w_dec.branch  = w_ok & w_br;
        w_dec.jump    = w_ok & w_jmp;
    end

    bundle_t              r_out;
    logic                 r_out_v;
    logic [ILL_CNT_W-1:0] r_cnt;
    logic                 w_fire;
    logic                 w_acc;
    logic                 w_rdy;

    assign w_fire   = r_out_v & out_ready;
    assign in_ready = w_rdy & ~flush;
    assign w_acc    = in_valid & in_ready;

`ifdef DECODE_SKID_EN
    bundle_t r_skid;
    logic    r_skid_v;

    assign w_rdy = ~r_skid_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= '0;
            r_out_v  <= 1'b0;
            r_skid   <= '0;
            r_skid_v <= 1'b0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            if (w_fire && r_out.illegal && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            if (r_skid_v) begin
                if (w_fire || !r_out_v) begin
                    r_out    <= r_skid;
                    r_out_v  <= 1'b1;
                    r_skid_v <= 1'b0;
                end
            end else if (w_acc) begin
                if (w_fire || !r_out_v) begin
                    r_out   <= w_dec;
                    r_out_v <= 1'b1;
                end else begin
                    r_skid   <= w_dec;
                    r_skid_v <= 1'b1;
                end
            end else if (w_fire) begin
                r_out_v <= 1'b0;
            end
        end
    end
`else
    assign w_rdy = ~r_out_v | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_out_v <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_out_v <= 1'b0;
        end else begin
            if (w_fire && r_out.illegal && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            if (w_acc) begin
                r_out   <= w_dec;
                r_out_v <= 1'b1;
            end else if (w_fire) begin
                r_out_v <= 1'b0;
            end
        end
    end
`endif

    assign out_valid   = r_out_v;
    assign out_pc      = r_out.pc;
    assign inst_type   = r_out.itype;
    assign alu_op_type = r_out.alu;
    assign sext_out    = r_out.imm;
    assign rs1         = r_out.rs1;
    assign rs2         = r_out.rs2;
    assign rd          = r_out.rd;
    assign rd_we       = r_out.rd_we;
    assign mem_rd      = r_out.mem_rd;
    assign mem_wr      = r_out.mem_wr;
    assign branch      = r_out.branch;
    assign jump        = r_out.jump;
    assign illegal     = r_out.illegal;
    assign ill_cnt     = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage checked
// against a queue-based transaction model with table-driven decode.
module tb_decode_stage;

    localparam int CW = 3;
`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam logic [4:0] T_NONE = 5'd0, T_R = 5'd1, T_I = 5'd2, T_S = 5'd3;
    localparam logic [4:0] T_B = 5'd4, T_U = 5'd5, T_J = 5'd6;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3;
    localparam logic [3:0] A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7;
    localparam logic [3:0] A_LT = 4'd8, A_EQ = 4'd9, A_NE = 4'd10, A_GE = 4'd11;

    localparam logic [3:0] OP_TAB [8] = '{A_ADD, A_SLL, A_LT, A_ADD,
                                          A_XOR, A_SRL, A_OR, A_AND};
    localparam logic [3:0] BR_TAB [8] = '{A_EQ, A_NE, A_ADD, A_ADD,
                                          A_LT, A_GE, A_ADD, A_ADD};

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  itype;
        logic [3:0]  alu;
        logic [31:0] sext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [4:0]    inst_type;
    logic [3:0]    alu_op_type;
    logic [31:0]   sext_out;
    logic [4:0]    rs1, rs2, rd;
    logic          rd_we, mem_rd, mem_wr, branch, jump, illegal;
    logic [CW-1:0] ill_cnt;

    decode_stage #(.ILL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .inst_type(inst_type), .alu_op_type(alu_op_type), .sext_out(sext_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump),
        .illegal(illegal), .ill_cnt(ill_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mcnt = 0;
    bit   last_acc;
    int   dut_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int s, hi, imm;
        bit ok, we, f7z, f7a;
        logic [3:0] alu;
        logic [2:0] f3;
        s = i;
        hi = s >>> 31;
        f3 = i[14:12];
        f7z = (i[31:25] == 7'h00);
        f7a = (i[31:25] == 7'h20);
        e = '0;
        e.pc = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd = i[11:7];
        ok = 0; we = 0; alu = A_ADD; imm = 0;
        case (i[6:0])
            7'h33: begin
                e.itype = T_R; we = 1; alu = OP_TAB[f3];
                ok = (f3 != 3'd3) && (f7z || (f7a && (f3 == 3'd0 || f3 == 3'd5)));
                if (f7a) alu = (f3 == 3'd0) ? A_SUB : A_SRA;
            end
            7'h13: begin
                e.itype = T_I; we = 1; alu = OP_TAB[f3];
                imm = s >>> 20;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    imm = int'(i[24:20]);
                    ok = f7z || (f3 == 3'd5 && f7a);
                    if (f7a) alu = A_SRA;
                end else ok = (f3 != 3'd3);
            end
            7'h03: begin
                e.itype = T_I; imm = s >>> 20; ok = (f3 == 3'd2);
                e.mem_rd = 1; we = 1;
            end
            7'h23: begin
                e.itype = T_S; ok = (f3 == 3'd2); e.mem_wr = 1;
                imm = (s >>> 25) * 32 + int'(i[11:7]);
            end
            7'h63: begin
                e.itype = T_B; e.branch = 1; alu = BR_TAB[f3];
                ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
                imm = hi * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'h37: begin
                e.itype = T_U; imm = s >>> 12; alu = A_SLL; ok = 1; we = 1;
            end
            7'h6F: begin
                e.itype = T_J; e.jump = 1; ok = 1; we = 1;
                imm = hi * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                      + int'(i[30:21]) * 2;
            end
            7'h67: begin
                e.itype = T_I; imm = s >>> 20; e.jump = 1; we = 1; ok = (f3 == 3'd0);
            end
            default: ;
        endcase
        e.sext = imm;
        e.illegal = !ok;
        if (ok) begin
            e.alu = alu;
            e.rd_we = we && (e.rd != 5'd0);
        end else begin
            e.alu = A_ADD;
            e.mem_rd = 0; e.mem_wr = 0; e.branch = 0; e.jump = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] w;
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67, 7'h17, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 2);
        if (k == 0) w[31:25] = 7'h00;
        else if (k == 1) w[31:25] = 7'h20;
        w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    // one clock of checking plus model update; inputs must be set beforehand
    task automatic cyc();
        exp_t obs;
        logic exp_rdy;
        bit   fire;
        #1;
        exp_rdy = !flush && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, q.size() > 0);
        chk("ill_cnt", ill_cnt, mcnt);
        if (in_valid && in_ready) dut_acc++;
        if (q.size() > 0) begin
            obs = {out_pc, inst_type, alu_op_type, sext_out, rs1, rs2, rd,
                   rd_we, mem_rd, mem_wr, branch, jump, illegal};
            chk("bundle", obs, q[0]);
        end
        fire = (q.size() > 0) && out_ready;
        last_acc = in_valid && exp_rdy && !flush;
        if (flush) q.delete();
        else begin
            if (fire) begin
                if (q[0].illegal && mcnt < (1 << CW) - 1) mcnt++;
                void'(q.pop_front());
            end
            if (last_acc) q.push_back(model(in_inst, in_pc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ill_cnt", ill_cnt, 0);
        chk("rst_bundle", {out_pc, inst_type, alu_op_type, sext_out, rs1, rs2, rd,
                           rd_we, mem_rd, mem_wr, branch, jump, illegal}, 0);
        rst = 1'b0;

        in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h100;
        cyc();
        in_valid = 0;
        chk("addi_valid", out_valid, 1);
        chk("addi_type", inst_type, T_I);
        chk("addi_alu", alu_op_type, A_ADD);
        chk("addi_rd", rd, 1);
        chk("addi_rs1", rs1, 0);
        chk("addi_imm", sext_out, 32'h5);
        chk("addi_we", rd_we, 1);

        in_valid = 1; in_inst = 32'h402081B3; in_pc = 32'h104;
        cyc();
        chk("sub_type", inst_type, T_R);
        chk("sub_alu", alu_op_type, A_SUB);
        chk("sub_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
        in_inst = 32'h4030D213; in_pc = 32'h108;
        cyc();
        chk("srai_alu", alu_op_type, A_SRA);
        chk("srai_imm", sext_out, 32'h3);

        in_inst = 32'h123452B7; in_pc = 32'h10C;
        cyc();
        chk("lui_type", inst_type, T_U);
        chk("lui_alu", alu_op_type, A_SLL);
        chk("lui_imm", sext_out, 32'h00012345);
        in_inst = 32'hFE208EE3; in_pc = 32'h110;
        cyc();
        chk("beq_type", inst_type, T_B);
        chk("beq_alu", alu_op_type, A_EQ);
        chk("beq_imm", sext_out, 32'hFFFFFFFC);
        chk("beq_flags", {branch, rd_we}, 2'b10);

        in_inst = 32'h0020E063; in_pc = 32'h114;
        cyc();
        chk("bltu_ill", {illegal, rd_we}, 2'b10);
        chk("bltu_cnt0", ill_cnt, 0);
        in_pc = 32'h118;
        cyc();
        chk("bltu_cnt1", ill_cnt, 1);
        in_valid = 0;
        cyc();
        chk("bltu_cnt2", ill_cnt, 2);

        out_ready = 0; in_valid = 1; in_inst = 32'h00A38333; in_pc = 32'h200;
        cyc();
        dut_acc = 0;
        for (int k = 0; k < 3; k++) begin
            if (last_acc) begin in_inst = rand_inst(); in_pc += 4; end
            cyc();
        end
        chk("stall_accepts", dut_acc, SKID ? 1 : 0);
        chk("stall_rdy", in_ready, 0);
        out_ready = 1; in_valid = 0;
        repeat (3) cyc();

        out_ready = 0; in_valid = 1; in_inst = rand_inst(); in_pc = 32'h300;
        cyc();
        in_inst = rand_inst(); in_pc = 32'h304;
        cyc();
        flush = 1; in_inst = rand_inst(); in_pc = 32'h500;
        cyc();
        flush = 0; in_valid = 0;
        #1;
        chk("flush_valid", out_valid, 0);
        in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h600; out_ready = 1;
        cyc();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_pc", out_pc, 32'h600);
        in_valid = 0;
        cyc();

        in_valid = 1; in_inst = 32'h00000073;
        for (int k = 0; k < 9; k++) begin
            in_pc = 32'h700 + 32'(k * 4);
            cyc();
        end
        in_valid = 0;
        cyc();
        chk("ill_sat", ill_cnt, 3'd7);

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_inst   = rand_inst();
            in_pc     = 32'h1000 + 32'(k * 4);
            cyc();
        end
        flush = 0;

        out_ready = 0; in_valid = 1; in_inst = rand_inst(); in_pc = 32'h2000;
        cyc();
        in_inst = rand_inst(); in_pc = 32'h2004;
        cyc();
        in_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", ill_cnt, 0);
        chk("mid_rst_rdy", in_ready, 1);
        rst = 0;
        q.delete();
        mcnt = 0;
        out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            in_valid = ($urandom_range(0, 1) != 0);
            in_inst  = rand_inst();
            in_pc    = 32'h3000 + 32'(k * 4);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
